// File: rtl/frame_transmitter.sv
// frame_transmitter: serialises a payload word MSB byte first, appends a
// CRC-16/BUYPASS checksum and separates frames with K28.1 comma symbols.
// One symbol is emitted per word tick.
module frame_transmitter #(
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter int unsigned MIN_COMMAS    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       word_tick_i,
  input  logic                       send_i,
  input  logic [8*PAYLOAD_BYTES-1:0] payload_i,
  output logic                       ready_o,
  output logic [7:0]                 data_o,
  output logic                       k_o,
  output logic                       frame_start_o,
  output logic                       frame_sent_o
);

  localparam int unsigned PW = 8 * PAYLOAD_BYTES;
  localparam int unsigned CW = $clog2(MIN_COMMAS + 1);
  localparam int unsigned BW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [7:0]  COMMA_SYM = 8'h3C;

  typedef enum logic [1:0] {
    S_COMMA,
    S_PAYLOAD,
    S_CRC_HI,
    S_CRC_LO
  } state_t;

  state_t          state;
  logic [PW-1:0]   hold;
  logic [PW-1:0]   shift;
  logic            pending;
  logic [15:0]     crc;
  logic [BW-1:0]   byte_cnt;
  logic [CW-1:0]   comma_cnt;

  logic            accept;
  logic            start;
  logic            pending_next;
  logic [7:0]      hold_head;
  logic [7:0]      shift_head;

  // CRC-16 poly 0x8005, one byte, MSB first, no reflection
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic [7:0]  d;
    r = c;
    d = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ d[7]) r = (r << 1) ^ 16'h8005;
      else              r = r << 1;
      d = d << 1;
    end
    return r;
  endfunction

  // Acceptance / frame-start decode; a start and a new acceptance may coincide
  always_comb begin
    accept       = send_i && ready_o;
    start        = word_tick_i && (state == S_COMMA) && pending &&
                   (comma_cnt >= CW'(MIN_COMMAS));
    pending_next = pending;
    if (start)  pending_next = 1'b0;
    if (accept) pending_next = 1'b1;
    hold_head    = hold[PW-1 -: 8];
    shift_head   = shift[PW-1 -: 8];
  end

  // Holding register and registered ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      ready_o <= 1'b1;
      hold    <= '0;
    end else begin
      pending <= pending_next;
      ready_o <= !pending_next;
      if (accept) hold <= payload_i;
    end
  end

  // Symbol sequencer: commas, payload bytes, CRC high, CRC low
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_COMMA;
      comma_cnt     <= CW'(MIN_COMMAS);
      crc           <= '0;
      shift         <= '0;
      byte_cnt      <= '0;
      data_o        <= COMMA_SYM;
      k_o           <= 1'b1;
      frame_start_o <= 1'b0;
      frame_sent_o  <= 1'b0;
    end else begin
      frame_start_o <= 1'b0;
      frame_sent_o  <= 1'b0;
      if (word_tick_i) begin
        case (state)
          S_COMMA: begin
            if (start) begin
              data_o        <= hold_head;
              k_o           <= 1'b0;
              shift         <= hold << 8;
              crc           <= crc_step('0, hold_head);
              byte_cnt      <= BW'(1);
              frame_start_o <= 1'b1;
              state         <= (PAYLOAD_BYTES == 1) ? S_CRC_HI : S_PAYLOAD;
            end else begin
              data_o <= COMMA_SYM;
              k_o    <= 1'b1;
              if (comma_cnt < CW'(MIN_COMMAS)) comma_cnt <= comma_cnt + CW'(1);
            end
          end
          S_PAYLOAD: begin
            data_o <= shift_head;
            k_o    <= 1'b0;
            shift  <= shift << 8;
            crc    <= crc_step(crc, shift_head);
            if (byte_cnt == BW'(PAYLOAD_BYTES - 1)) state <= S_CRC_HI;
            else                                    byte_cnt <= byte_cnt + BW'(1);
          end
          S_CRC_HI: begin
            data_o <= crc[15:8];
            k_o    <= 1'b0;
            state  <= S_CRC_LO;
          end
          S_CRC_LO: begin
            data_o       <= crc[7:0];
            k_o          <= 1'b0;
            frame_sent_o <= 1'b1;
            comma_cnt    <= '0;
            state        <= S_COMMA;
          end
          default: state <= S_COMMA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter with PAYLOAD_BYTES=9, MIN_COMMAS=2.
module tb_frame_transmitter;

  localparam int N = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          word_tick_i;
  logic          send_i;
  logic [71:0]   payload_i;
  logic          ready_o;
  logic [7:0]    data_o;
  logic          k_o;
  logic          frame_start_o;
  logic          frame_sent_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sym_d;
  logic       sym_k;
  logic       sym_st;
  logic       sym_se;

  // "123456789" -> CRC 0xFEE8; all zero -> 0x0000; zeros then 0x01 -> 0x8005
  localparam logic [71:0] P1   = 72'h313233343536373839;
  localparam logic [71:0] P2   = 72'h000000000000000000;
  localparam logic [71:0] P3   = 72'h000000000000000001;
  localparam logic [71:0] JUNK = 72'hFFFFFFFFFFFFFFFFFF;

  frame_transmitter #(.PAYLOAD_BYTES(N), .MIN_COMMAS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .word_tick_i   (word_tick_i),
    .send_i        (send_i),
    .payload_i     (payload_i),
    .ready_o       (ready_o),
    .data_o        (data_o),
    .k_o           (k_o),
    .frame_start_o (frame_start_o),
    .frame_sent_o  (frame_sent_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One symbol tick followed by period-1 idle clocks; output must hold and pulses stay low
  task automatic emit(input int period);
    word_tick_i = 1'b1;
    @(posedge clk);
    #1;
    sym_d  = data_o;
    sym_k  = k_o;
    sym_st = frame_start_o;
    sym_se = frame_sent_o;
    send_i      = 1'b0;
    word_tick_i = 1'b0;
    for (int j = 1; j < period; j++) begin
      @(posedge clk);
      #1;
      check_eq("hold_data", 16'(data_o), 16'(sym_d));
      check_eq("hold_k", 16'(k_o), 16'(sym_k));
      check_eq("start_width", 16'(frame_start_o), 16'h0);
      check_eq("sent_width", 16'(frame_sent_o), 16'h0);
    end
  endtask

  task automatic check_comma(input int period);
    emit(period);
    check_eq("comma_data", 16'(sym_d), 16'h003C);
    check_eq("comma_k", 16'(sym_k), 16'h1);
  endtask

  task automatic check_reset_state();
    check_eq("rst_data", 16'(data_o), 16'h003C);
    check_eq("rst_k", 16'(k_o), 16'h1);
    check_eq("rst_ready", 16'(ready_o), 16'h1);
    check_eq("rst_start", 16'(frame_start_o), 16'h0);
    check_eq("rst_sent", 16'(frame_sent_o), 16'h0);
  endtask

  // Checks the first n_sym symbols of a frame whose first byte comes on the next tick.
  // Optionally issues an accepted send at accept_at and an ignored send at junk_at.
  task automatic check_frame(input logic [71:0] p, input logic [15:0] c, input int period,
                             input int accept_at, input logic [71:0] ap,
                             input int junk_at, input int n_sym);
    logic [7:0] eb;
    for (int i = 0; i < n_sym; i++) begin
      if (i == accept_at) begin
        send_i = 1'b1;
        payload_i = ap;
      end else if (i == junk_at) begin
        send_i = 1'b1;
        payload_i = JUNK;
      end
      if (i < N)       eb = p[8*(N-1-i) +: 8];
      else if (i == N) eb = c[15:8];
      else             eb = c[7:0];
      emit(period);
      check_eq("frame_data", 16'(sym_d), 16'(eb));
      check_eq("frame_k", 16'(sym_k), 16'h0);
      check_eq("frame_start", 16'(sym_st), 16'(i == 0));
      check_eq("frame_sent", 16'(sym_se), 16'(i == N + 1));
      if (i == 0 && accept_at != 0) check_eq("ready_rise", 16'(ready_o), 16'h1);
      if (i == accept_at) check_eq("ready_fall", 16'(ready_o), 16'h0);
      if (i == junk_at) check_eq("ready_busy", 16'(ready_o), 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    word_tick_i = 1'b1;
    send_i      = 1'b0;
    payload_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;

    // Single frame "123456789", tick every clk; payload_i changed after acceptance
    send_i = 1'b1;
    payload_i = P1;
    emit(1);
    payload_i = JUNK;
    check_eq("accept_ready", 16'(ready_o), 16'h0);
    check_eq("accept_data", 16'(sym_d), 16'h003C);
    check_frame(P1, 16'hFEE8, 1, -1, '0, -1, N + 2);
    check_comma(1);
    check_comma(1);
    check_eq("idle_ready", 16'(ready_o), 16'h1);

    // Back-to-back: second send accepted during frame, third ignored while busy
    send_i = 1'b1;
    payload_i = P2;
    emit(1);
    check_eq("b2b_accept_ready", 16'(ready_o), 16'h0);
    check_frame(P2, 16'h0000, 1, 1, P3, 3, N + 2);
    check_comma(1);
    check_comma(1);
    check_eq("b2b_pending", 16'(ready_o), 16'h0);
    check_frame(P3, 16'h8005, 1, -1, '0, -1, N + 2);
    check_comma(1);
    check_comma(1);
    check_eq("b2b_idle_ready", 16'(ready_o), 16'h1);

    // Tick every 4th clock: same sequence, each symbol held 4 clocks
    send_i = 1'b1;
    payload_i = P1;
    emit(4);
    check_eq("slow_accept_ready", 16'(ready_o), 16'h0);
    check_frame(P1, 16'hFEE8, 4, -1, '0, -1, N + 2);
    check_comma(4);
    check_comma(4);

    // Reset while byte 3 is on the line, then a clean frame
    word_tick_i = 1'b1;
    send_i = 1'b1;
    payload_i = P1;
    emit(1);
    check_frame(P1, 16'hFEE8, 1, -1, '0, -1, 4);
    reset = 1'b1;
    word_tick_i = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    send_i = 1'b1;
    payload_i = P3;
    emit(1);
    check_eq("post_rst_data", 16'(sym_d), 16'h003C);
    check_frame(P3, 16'h8005, 1, -1, '0, -1, N + 2);
    check_comma(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_transmitter.md
# frame_transmitter

Transmit side of the time-distribution pulse-id link: accepts a payload word, serialises it MSB byte first, appends a CRC-16/BUYPASS checksum (poly 0x8005, init 0, no reflection, no output XOR), and brackets every frame with K28.1 comma symbols. It feeds the 8b/10b encoder, one symbol per word tick, and produces exactly the symbol stream the frame receiver on the far end accepts: a receiver-side CRC over payload+CRC yields 0.

## Interface
- PAYLOAD_BYTES, 8, payload length in bytes (≥1); frame = PAYLOAD_BYTES + 2 bytes.
- MIN_COMMAS, 2, minimum number of comma symbols between consecutive frames (≥1).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- word_tick_i  in  1  symbol strobe from the link clocking (tie to 1 for the high-speed link); one symbol is emitted per tick.
- send_i  in  1  request to send payload_i; accepted on a clk edge where send_i & ready_o.
- payload_i  in  8*PAYLOAD_BYTES  payload, sampled only at acceptance.
- ready_o  out  1  holding register empty; a request can be accepted.
- data_o  out  8  symbol to the 8b/10b encoder; 8'h3C when k_o=1.
- k_o  out  1  1 = control symbol (K28.1 comma), 0 = data byte.
- frame_start_o  out  1  one-clk pulse when the first payload byte is loaded onto data_o.
- frame_sent_o  out  1  one-clk pulse when the CRC low byte is loaded onto data_o.

## Operation
- Holding register: one payload deep. Acceptance loads hold, sets pending (ready_o=0). Pending clears on the edge the frame starts; a new request may be accepted on that same edge (hold reloaded, pending stays 1).
- State machine (advances only on clk edges with word_tick_i=1; otherwise all state, counters, outputs hold):
  - COMMA: emit comma, increment comma counter (saturating at MIN_COMMAS). If pending and counter already ≥ MIN_COMMAS, instead emit payload byte 0 (payload[8N-1:8N-8]), copy hold into shift register, clear CRC to 0 and update it with byte 0, go to PAYLOAD; pulse frame_start_o.
  - PAYLOAD: emit next payload byte (descending order), update CRC with it; after byte N-1 go to CRC_HI.
  - CRC_HI: emit crc[15:8], go CRC_LO.
  - CRC_LO: emit crc[7:0], pulse frame_sent_o, clear comma counter, go COMMA.
- Comma counter counts commas emitted since the last CRC_LO; with no pending request the block idles in COMMA indefinitely emitting commas.
- CRC update per byte: 8 iterations MSB first, crc = (crc<<1) ^ (0x8005 if (crc[15] ^ bit)); 16-bit, combinational next value, registered on the emitting edge. CRC covers payload bytes only.
- send_i while ready_o=0 is ignored (not queued); payload_i never affects a frame already in shift register.
- Reset (any time, including mid-frame): state COMMA, comma counter = MIN_COMMAS (so a frame may start on the first tick after reset), pending=0, crc=0. A partially sent frame is abandoned; the receiver drops it via CRC/comma.

## Timing
- Reset values: data_o=8'h3C, k_o=1, ready_o=1, frame_start_o=0, frame_sent_o=0.
- All outputs registered; data_o/k_o change only on clk edges with word_tick_i=1.
- ready_o falls the edge after acceptance and rises the edge the frame starts.
- Latency, idle link, word_tick_i=1 continuously, counter saturated: accept at edge E → byte 0 on data_o after edge E+1; frame occupies N+2 ticks; next frame starts no earlier than MIN_COMMAS ticks after CRC_LO.
- Back-to-back requests: sustained rate one frame per N+2+MIN_COMMAS ticks.
- frame_start_o/frame_sent_o are 1 clk wide regardless of word_tick_i spacing.

## Test plan
- PAYLOAD_BYTES=9, payload 0x313233343536373839 ("123456789"), tick=1 → data_o 31..39, FE, E8 with k_o=0, surrounded by 3C/k_o=1; frame_sent_o on E8.
- Two back-to-back sends (second while first in flight, MIN_COMMAS=2) → exactly 2 commas between frames, second frame correct, ready_o timing as specified.
- word_tick_i every 4th clk → each symbol held 4 clks, identical sequence to tick=1 case, pulses 1 clk wide.
- send_i while ready_o=0 with different payload → ignored; transmitted frame uses held payload.
- Reset asserted during PAYLOAD byte 3 → next clk data_o=3C, k_o=1, ready_o=1; new send starts clean frame with correct CRC.
- Loopback into frame receiver with random payloads, 1000 frames → every frame ticks, payload matches, error_o never set.
